// File: rtl/wht_bfly_sched.sv
// ============================================================================
// Module   : wht_bfly_sched
// Summary  : Block scheduler that drives one external add/sub butterfly to
//            produce an N-point natural-order Walsh-Hadamard transform.
//            Optional macro OVF_FLAG_EN builds the sticky overflow detector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wht_bfly_sched #(
    parameter int W     = 15,
    parameter int N     = 8,
    parameter int LOG2N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] bf_ai,
    output logic [W-1:0] bf_bi,
    input  logic [W-1:0] bf_ao,
    input  logic [W-1:0] bf_bo,
    output logic         busy,
    output logic         done,
    output logic         ovf
);

    localparam int KW = LOG2N - 1;
    localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;

    localparam logic [LOG2N-1:0] c_idx_last   = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] c_one        = LOG2N'(1);
    localparam logic [KW-1:0]    c_k_last     = KW'(N / 2 - 1);
    localparam logic [SW-1:0]    c_stage_last = SW'(LOG2N - 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    logic [W-1:0]     r_mem [N];
    logic [LOG2N-1:0] r_idx;
    logic [KW-1:0]    r_k;
    logic [SW-1:0]    r_stage;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_done;

    logic [LOG2N-1:0] w_k_ext;
    logic [LOG2N-1:0] w_h;
    logic [LOG2N-1:0] w_mask;
    logic [LOG2N-1:0] w_i;
    logic [LOG2N-1:0] w_j;
    logic             w_load_acc;
    logic             w_run;

    // Pair index: insert a zero at bit s of k, so i has bit s clear and j = i | h.
    always_comb begin
        w_k_ext = {1'b0, r_k};
        w_h     = c_one << r_stage;
        w_mask  = w_h - c_one;
        w_i     = (w_k_ext & w_mask) | ((w_k_ext & ~w_mask) << 1);
        w_j     = w_i | w_h;
    end

    assign w_load_acc = (r_state == ST_LOAD) && in_valid;
    assign w_run      = (r_state == ST_RUN);

    assign bf_ai     = w_run ? r_mem[w_i] : '0;
    assign bf_bi     = w_run ? r_mem[w_j] : '0;
    assign out_data  = r_out_valid ? r_mem[r_idx] : '0;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign done      = r_done;

    always_ff @(posedge clk) begin
        if (w_load_acc) begin
            r_mem[r_idx] <= in_data;
        end else if (w_run) begin
            r_mem[w_i] <= bf_ao;
            r_mem[w_j] <= bf_bo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_LOAD;
            r_idx       <= '0;
            r_k         <= '0;
            r_stage     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    if (in_valid) begin
                        if (r_idx == c_idx_last) begin
                            r_idx      <= '0;
                            r_state    <= ST_RUN;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b1;
                        end else begin
                            r_idx <= r_idx + c_one;
                        end
                    end
                end
                ST_RUN: begin
                    if (r_k == c_k_last) begin
                        r_k <= '0;
                        if (r_stage == c_stage_last) begin
                            r_stage     <= '0;
                            r_state     <= ST_DRAIN;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_stage <= r_stage + SW'(1);
                        end
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (r_idx == c_idx_last) begin
                            r_idx       <= '0;
                            r_state     <= ST_LOAD;
                            r_out_valid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_done      <= 1'b1;
                        end else begin
                            r_idx <= r_idx + c_one;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_LOAD;
                    r_idx       <= '0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef OVF_FLAG_EN
    logic r_ovf;
    logic w_sum_ovf;
    logic w_dif_ovf;

    // Signed overflow from operand/result sign bits of the wrapped butterfly.
    assign w_sum_ovf = (bf_ai[W-1] == bf_bi[W-1]) && (bf_ao[W-1] != bf_ai[W-1]);
    assign w_dif_ovf = (bf_ai[W-1] != bf_bi[W-1]) && (bf_bo[W-1] != bf_ai[W-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_load_acc && (r_idx == '0)) begin
            r_ovf <= 1'b0;
        end else if (w_run && (w_sum_ovf || w_dif_ovf)) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

endmodule

`default_nettype wire
